// File: rtl/esp_arb_pkg.sv
// rtl/esp_arb_pkg.sv - shared constants and state encoding for the ESP request arbiter
package esp_arb_pkg;

  localparam logic [2:0] ESP_S_TRS_IO_IN  = 3'd0;
  localparam logic [2:0] ESP_S_TRS_IO_OUT = 3'd1;
  localparam logic [2:0] ESP_S_FREHD_IN   = 3'd2;
  localparam logic [2:0] ESP_S_FREHD_OUT  = 3'd3;
  localparam logic [2:0] ESP_S_PRINTER_RD = 3'd4;
  localparam logic [2:0] ESP_S_PRINTER_WR = 3'd5;
  localparam logic [2:0] ESP_S_XRAY       = 3'd6;

  localparam int unsigned REQ_TRSIO   = 0;
  localparam int unsigned REQ_FREHD   = 1;
  localparam int unsigned REQ_PRINTER = 2;
  localparam int unsigned REQ_XRAY    = 3;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PULSE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/esp_req_arbiter_if.sv
// rtl/esp_req_arbiter_if.sv - requester and ESP pin bundle of the ESP request arbiter
interface esp_req_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]   req;
  logic [3*N-1:0] req_code;
  logic           esp_done;
  logic           err_clr;
  logic           esp_req;
  logic [2:0]     esp_s;
  logic           wait_out;
  logic [N-1:0]   grant;
  logic           done;
  logic           timeout_err;

  modport master (
    output req, req_code, esp_done, err_clr,
    input  esp_req, esp_s, wait_out, grant, done, timeout_err
  );

  modport slave (
    input  req, req_code, esp_done, err_clr,
    output esp_req, esp_s, wait_out, grant, done, timeout_err
  );
endinterface

// File: rtl/esp_req_arbiter_rr_pick.sv
// rtl/esp_req_arbiter_rr_pick.sv - round-robin find-first starting one slot after the pointer
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!valid && pend[(32'(ptr) + k) % N]) begin
        valid = 1'b1;
        idx   = IW'((32'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/esp_req_arbiter.sv
// rtl/esp_req_arbiter.sv - latches internal ESP requests, grants them round-robin and
// sequences ESP_REQ / ESP_S / WAIT until ESP_DONE or timeout
module esp_req_arbiter
  import esp_arb_pkg::*;
#(
  parameter int unsigned   N         = 4,
  parameter int unsigned   REQ_PULSE = 50,
  parameter int unsigned   TIMEOUT   = 2_000_000,
  parameter logic [N-1:0]  WAIT_MASK = 4'b0111
) (
  input logic clk,
  input logic reset,
  esp_req_arbiter_if.slave bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic [N-1:0]        pend_q, pend_d;
  logic [N-1:0][2:0]   code_q, code_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       win_q, win_d;
  logic [2:0]          cur_code_q, cur_code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                seen_q, seen_d;
  logic                done_q, done_d;
  logic                terr_q, terr_d;
  logic [2:0]          sync_q, sync_d;
  logic                done_edge_q, done_edge_d;

  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic                active;
  logic [N-1:0]        grant_oh;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .pend  (pend_q),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Two sync stages plus a delayed copy; the edge itself is registered once more.
  always_comb begin
    sync_d      = {sync_q[1:0], bus.esp_done};
    done_edge_d = sync_q[1] & ~sync_q[2];
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    code_d     = code_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cur_code_d = cur_code_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    seen_d     = seen_q;
    done_d     = 1'b0;
    terr_d     = terr_q;

    for (int unsigned i = 0; i < N; i++) begin
      if (bus.req[i] && !pend_q[i]) begin
        pend_d[i] = 1'b1;
        code_d[i] = bus.req_code[3*i +: 3];
      end
    end

    if (bus.err_clr) begin
      terr_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          pend_d[pick_idx] = 1'b0;
          ptr_d            = pick_idx;
          win_d            = pick_idx;
          cur_code_d       = code_q[pick_idx];
          cnt_d            = CNT_W'(REQ_PULSE);
          seen_d           = 1'b0;
          state_d          = ST_PULSE;
        end
      end
      ST_PULSE: begin
        seen_d = seen_q | done_edge_q;
        if (cnt_q == CNT_W'(1)) begin
          tmo_d   = TW'(TIMEOUT - REQ_PULSE);
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        // A real completion beats a timeout expiring in the same cycle.
        if (seen_q || done_edge_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_q == TW'(1)) begin
          done_d  = 1'b1;
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      code_q      <= '0;
      ptr_q       <= IW'(N - 1);
      win_q       <= '0;
      cur_code_q  <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      seen_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
      sync_q      <= '0;
      done_edge_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      code_q      <= code_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cur_code_q  <= cur_code_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      seen_q      <= seen_d;
      done_q      <= done_d;
      terr_q      <= terr_d;
      sync_q      <= sync_d;
      done_edge_q <= done_edge_d;
    end
  end

  always_comb begin
    active   = (state_q != ST_IDLE);
    grant_oh = '0;
    if (active) begin
      grant_oh[win_q] = 1'b1;
    end
  end

  assign bus.esp_req     = (state_q == ST_PULSE);
  assign bus.esp_s       = active ? cur_code_q : 3'd0;
  assign bus.wait_out    = active & WAIT_MASK[win_q];
  assign bus.grant       = grant_oh;
  assign bus.done        = done_q;
  assign bus.timeout_err = terr_q;

endmodule
